// File: rtl/decode_cycle_pkg.sv
// Shared decode definitions for the RV32I decode stage: opcodes, ALU and
// immediate-source encodings, and the decoded control bundle.
package decode_cycle_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_RTYPE  = 7'b0110011,
        OP_IALU   = 7'b0010011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    // IMM_NONE selects a zero immediate for R-type and unknown opcodes.
    typedef enum logic [1:0] {
        IMM_I    = 2'b00,
        IMM_S    = 2'b01,
        IMM_B    = 2'b10,
        IMM_NONE = 2'b11
    } imm_src_e;

    typedef struct packed {
        logic      reg_write;
        logic      mem_write;
        logic      result_src;
        logic      branch;
        logic      alu_src;
        alu_ctrl_e alu_ctrl;
        imm_src_e  imm_src;
    } ctrl_t;

endpackage

// File: rtl/decode_cycle_register_file.sv
// 32x32 register file: x0 hardwired to zero, two combinational reads, one
// synchronous write. Optional write-through selected by REGFILE_BYPASS_EN.
module register_file #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic            hit1;
    logic            hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit1 = we_i && (waddr_i != '0) && (waddr_i == raddr1_i);
    assign hit2 = we_i && (waddr_i != '0) && (waddr_i == raddr2_i);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rdata1_o = '0;
        rdata2_o = '0;
        if (hit1) begin
            rdata1_o = wdata_i;
        end else if (raddr1_i != '0) begin
            rdata1_o = regs_q[raddr1_i];
        end
        if (hit2) begin
            rdata2_o = wdata_i;
        end else if (raddr2_i != '0) begin
            rdata2_o = regs_q[raddr2_i];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extension, register file and
// ID/EX pipeline register. Define REGFILE_BYPASS_EN for register write-through.
module decode_cycle #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     InstrD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic            RegWriteW,
    input  logic [4:0]      RDW,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            ResultSrcE,
    output logic            BranchE,
    output logic            ALUSrcE,
    output logic [2:0]      ALUControlE,
    output logic [XLEN-1:0] RD1_E,
    output logic [XLEN-1:0] RD2_E,
    output logic [XLEN-1:0] Imm_Ext_E,
    output logic [4:0]      RD_E,
    output logic [4:0]      RS1_E,
    output logic [4:0]      RS2_E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E
);
    import decode_cycle_pkg::*;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            result_src;
        logic            branch;
        logic            alu_src;
        logic [2:0]      alu_ctrl;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } idex_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            f7b5;
    alu_ctrl_e       alu_arith;
    ctrl_t           ctrl;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode = InstrD[6:0];
    assign rd     = InstrD[11:7];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign f7b5   = InstrD[30];

    register_file #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (5)
    ) u_register_file (
        .clk      (clk),
        .rst      (rst),
        .we_i     (RegWriteW),
        .waddr_i  (RDW),
        .wdata_i  (ResultW),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rd1),
        .rdata2_o (rd2)
    );

    // f7b5 selects subtract only for R-type; I-ALU addi must never become sub.
    always_comb begin
        alu_arith = ALU_ADD;
        case (funct3)
            3'b000:  alu_arith = ((opcode == OP_RTYPE) && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_arith = ALU_SLT;
            3'b110:  alu_arith = ALU_OR;
            3'b111:  alu_arith = ALU_AND;
            default: alu_arith = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl          = '0;
        ctrl.alu_ctrl = ALU_ADD;
        ctrl.imm_src  = IMM_NONE;
        case (opcode)
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = 1'b1;
                ctrl.imm_src    = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.imm_src   = IMM_S;
            end
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_ctrl  = alu_arith;
            end
            OP_IALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = alu_arith;
                ctrl.imm_src   = IMM_I;
            end
            OP_BRANCH: begin
                ctrl.branch   = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                ctrl.imm_src  = IMM_B;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_ext = '0;
        case (ctrl.imm_src)
            IMM_I:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                                InstrD[30:25], InstrD[11:8], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    always_comb begin
        idex_d            = '0;
        idex_d.reg_write  = ctrl.reg_write;
        idex_d.mem_write  = ctrl.mem_write;
        idex_d.result_src = ctrl.result_src;
        idex_d.branch     = ctrl.branch;
        idex_d.alu_src    = ctrl.alu_src;
        idex_d.alu_ctrl   = ctrl.alu_ctrl;
        idex_d.rd1        = rd1;
        idex_d.rd2        = rd2;
        idex_d.imm        = imm_ext;
        idex_d.rd         = rd;
        idex_d.rs1        = rs1;
        idex_d.rs2        = rs2;
        idex_d.pc         = PCD;
        idex_d.pc_plus4   = PCPlus4D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else if (FlushE) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign RegWriteE   = idex_q.reg_write;
    assign MemWriteE   = idex_q.mem_write;
    assign ResultSrcE  = idex_q.result_src;
    assign BranchE     = idex_q.branch;
    assign ALUSrcE     = idex_q.alu_src;
    assign ALUControlE = idex_q.alu_ctrl;
    assign RD1_E       = idex_q.rd1;
    assign RD2_E       = idex_q.rd2;
    assign Imm_Ext_E   = idex_q.imm;
    assign RD_E        = idex_q.rd;
    assign RS1_E       = idex_q.rs1;
    assign RS2_E       = idex_q.rs2;
    assign PCE         = idex_q.pc;
    assign PCPlus4E    = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// traffic against an instruction-level reference model.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E, RS1_E, RS2_E;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] mregs [32];
    logic [182:0] obs_all;
    logic [182:0] exp_all;

    always #5 clk = ~clk;

    decode_cycle #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
    );

    assign obs_all = {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
                      RD1_E, RD2_E, Imm_Ext_E, RD_E, RS1_E, RS2_E, PCE, PCPlus4E};

    function automatic logic [31:0] read_port(input logic [4:0] idx);
        logic [31:0] v;
        v = (idx == 5'd0) ? 32'd0 : mregs[idx];
`ifdef REGFILE_BYPASS_EN
        if (RegWriteW && RDW != 5'd0 && RDW == idx) v = ResultW;
`endif
        return v;
    endfunction

    // Instruction-level view: what an RV32I decoder must hand to execute.
    function automatic logic [182:0] model(input logic [31:0] ins);
        logic rw, mw, rsrc, br, asrc;
        logic [2:0] alu;
        logic [31:0] imm, ii, is, ib;
        rw = 0; mw = 0; rsrc = 0; br = 0; asrc = 0; alu = 3'd0; imm = 32'd0;
        ii = $signed(ins[31:20]);
        is = $signed({ins[31:25], ins[11:7]});
        ib = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
        case (ins[6:0])
            7'b0000011: begin rw = 1; asrc = 1; rsrc = 1; imm = ii; end
            7'b0100011: begin mw = 1; asrc = 1; imm = is; end
            7'b0110011, 7'b0010011: begin
                rw = 1;
                if (ins[6:0] == 7'b0010011) begin asrc = 1; imm = ii; end
                case (ins[14:12])
                    3'b000: alu = (ins[6:0] == 7'b0110011 && ins[30]) ? 3'b001 : 3'b000;
                    3'b110: alu = 3'b011;
                    3'b111: alu = 3'b010;
                    3'b010: alu = 3'b101;
                    default: alu = 3'b000;
                endcase
            end
            7'b1100011: begin br = 1; alu = 3'b001; imm = ib; end
            default: ;
        endcase
        return {rw, mw, rsrc, br, asrc, alu, read_port(ins[19:15]), read_port(ins[24:20]),
                imm, ins[11:7], ins[19:15], ins[24:20], PCD, PCPlus4D};
    endfunction

    function automatic logic [31:0] rd_instr(input logic [4:0] r);
        return {12'd0, r, 3'b000, 5'd0, 7'b0010011};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic we, input logic [4:0] wd,
                         input logic [31:0] wdat, input logic fl);
        InstrD = ins; RegWriteW = we; RDW = wd; ResultW = wdat; FlushE = fl;
        PCD = $urandom() & 32'hFFFF_FFFC;
        PCPlus4D = PCD + 32'd4;
    endtask

    task automatic cycle(output logic [182:0] exp);
        exp = (rst || FlushE) ? '0 : model(InstrD);
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        end else if (RegWriteW && RDW != 5'd0) begin
            mregs[RDW] = ResultW;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(32'h00500093, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        for (int c = 0; c < 2; c++) begin
            cycle(exp_all);
            n_tests++;
            if (obs_all !== exp_all || obs_all !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", obs_all, exp_all);
            end
        end
        rst = 1'b0;
        for (int r = 1; r < 32; r++) begin
            drive(rd_instr(5'(r)), 1'b0, 5'd0, 32'd0, 1'b0);
            cycle(exp_all);
            n_tests++;
            if (RD1_E !== 32'd0 || obs_all !== exp_all) begin
                n_fail++;
                $display("FAIL reset_readback x%0d: got %h expected %h", r, obs_all, exp_all);
            end
        end
    endtask

    task automatic test_addi();
        drive(32'h00500093, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RegWriteE !== 1'b1 || ALUSrcE !== 1'b1 || ALUControlE !== 3'b000 ||
            Imm_Ext_E !== 32'd5 || RD_E !== 5'd1 || RS1_E !== 5'd0 || RD1_E !== 32'd0 ||
            obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL addi: got %h expected %h", obs_all, exp_all);
        end
    endtask

    task automatic test_writeback_sub();
        drive(32'h0, 1'b1, 5'd1, 32'd7, 1'b0); cycle(exp_all);
        drive(32'h0, 1'b1, 5'd2, 32'd3, 1'b0); cycle(exp_all);
        drive(32'h402081B3, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RD1_E !== 32'd7 || RD2_E !== 32'd3 || ALUControlE !== 3'b001 ||
            RD_E !== 5'd3 || ALUSrcE !== 1'b0 || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL wb_sub: got %h expected %h", obs_all, exp_all);
        end
        drive(32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0); cycle(exp_all);
        drive(rd_instr(5'd0), 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RD1_E !== 32'd0 || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL x0_write: got %h expected 0", RD1_E);
        end
    endtask

    task automatic test_sw_beq();
        drive(32'h0020A423, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (MemWriteE !== 1'b1 || RegWriteE !== 1'b0 || Imm_Ext_E !== 32'd8 ||
            obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL sw: got %h expected %h", obs_all, exp_all);
        end
        drive(32'hFE000EE3, 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (BranchE !== 1'b1 || ALUControlE !== 3'b001 || Imm_Ext_E !== 32'hFFFF_FFFC ||
            obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL beq: got %h expected %h", obs_all, exp_all);
        end
    endtask

    task automatic test_flush();
        drive(32'h0000A183, 1'b1, 5'd5, 32'd9, 1'b1);
        cycle(exp_all);
        n_tests++;
        if (obs_all !== '0 || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL flush_bubble: got %h expected 0", obs_all);
        end
        drive(rd_instr(5'd5), 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RD1_E !== 32'd9 || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL flush_writeback: got %h expected 9", RD1_E);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'h55;
`else
        want = mregs[1];
`endif
        drive(rd_instr(5'd1), 1'b1, 5'd1, 32'h55, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RD1_E !== want || obs_all !== exp_all) begin
            n_fail++;
            $display("FAIL same_cycle_rw: got %h expected %h", RD1_E, want);
        end
        drive(rd_instr(5'd1), 1'b0, 5'd0, 32'd0, 1'b0);
        cycle(exp_all);
        n_tests++;
        if (RD1_E !== 32'h55) begin
            n_fail++;
            $display("FAIL same_cycle_after: got %h expected 00000055", RD1_E);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        logic [31:0] ins;
        int unsigned pick;
        for (int n = 0; n < 400; n++) begin
            ins  = $urandom();
            pick = $urandom_range(0, 5);
            if (pick < 5) ins[6:0] = ops[pick];
            drive(ins, 1'($urandom_range(0, 1)), 5'($urandom()), $urandom(),
                  ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 3) == 0) InstrD[19:15] = RDW;
            if ($urandom_range(0, 3) == 0) InstrD[24:20] = RDW;
            rst = ($urandom_range(0, 49) == 0);
            cycle(exp_all);
            n_tests++;
            if (obs_all !== exp_all) begin
                n_fail++;
                $display("FAIL random[%0d] instr %h: got %h expected %h", n, ins, obs_all, exp_all);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(32'h0, 1'b0, 5'd0, 32'd0, 1'b0);
        test_reset();
        test_addi();
        test_writeback_sub();
        test_sw_beq();
        test_flush();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second stage of the five-stage RV32I pipeline. Consumes the IF/ID outputs of the fetch stage (InstrD, PCD, PCPlus4D) and decodes the instruction. Holds the 32×32 register file with its writeback port and registers everything the execute stage needs into the ID/EX pipeline register. A flush input lets the hazard unit insert bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, register count (index width 5)

Ports (clk and rst first):
- clk  in  1  single pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  load bubble into ID/EX at next edge
- RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE  out  1 each  registered control
- ALUControlE  out  3  registered ALU op
- RD1_E, RD2_E  out  32  registered operands
- Imm_Ext_E  out  32  registered sign-extended immediate
- RD_E, RS1_E, RS2_E  out  5  registered register indices
- PCE, PCPlus4E  out  32  registered PCs

## Operation
- Fields: opcode=InstrD[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20], f7b5=[30].
- Decoded opcodes:
  - 0000011 lw: RegWrite, ALUSrc, ResultSrc=1, ImmSrc I.
  - 0100011 sw: MemWrite, ALUSrc, ImmSrc S.
  - 0110011 R-type: RegWrite.
  - 0010011 I-ALU: RegWrite, ALUSrc, ImmSrc I.
  - 1100011 beq: Branch, ALUControl=sub, ImmSrc B.
  - Any other opcode: all control 0, ALUControl=000 (NOP).
- ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 slt.
  - R-type f3=000 with f7b5=1 gives sub; otherwise f3 selects (000 add, 110 or, 111 and, 010 slt).
  - I-ALU ignores f7b5.
  - lw/sw use add.
- Immediate extension:
  - I: sext(InstrD[31:20]).
  - S: sext({[31:25],[11:7]}).
  - B: sext({[31],[7],[30:25],[11:8],1'b0}).
  - Immediate is undefined-but-stable (0) for R-type/NOP.
- Register file:
  - Two combinational read ports (rs1, rs2) and one synchronous write port.
  - Write at rising edge when RegWriteW=1 and RDW≠0.
  - x0 always reads 0; writes to x0 are discarded.
- ID/EX register:
  - Loads every cycle from the decode results.
  - FlushE=1 loads a bubble: all outputs 0.

## Timing
- Latency: InstrD at cycle N appears on the *E outputs after edge N+1 (1 cycle).
- Reset (rst=1 at an edge): all ID/EX outputs 0 and all 32 registers 0. Reset takes priority over FlushE and over writeback.
- Priority at an edge: rst > FlushE > normal load.
- FlushE flushes only ID/EX. The register file write still occurs in the same cycle.
- A write and a read to the same register in the same cycle: see Configuration.
- Reset mid-stream discards the in-flight instruction. The next non-reset edge loads the current InstrD normally.

## Configuration
- REGFILE_BYPASS_EN:
  - Defined: internal write-through. When RegWriteW=1, RDW≠0 and RDW equals rs1/rs2, the read port returns ResultW in that cycle, so RD1_E/RD2_E capture the new value.
  - Undefined: read ports return the pre-write value. The new value is visible from the following cycle, and the hazard unit must cover the gap.

## Structure
- Shared package holds:
  - Opcode constants: OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU, OP_BRANCH.
  - ALUControl encodings.
  - ImmSrc encodings (IMM_I=00, IMM_S=01, IMM_B=10).
  - XLEN.
- One sub-module: register_file (32×32, x0 hardwired, optional bypass). Control decode, sign-extend and ID/EX register live in decode_cycle.

## Test plan
- Reset: rst=1 for 2 cycles with InstrD=0x00500093 → all *E outputs 0. Readback of x1..x31 via rs1 returns 0.
- addi: InstrD=0x00500093 → next cycle RegWriteE=1, ALUSrcE=1, ALUControlE=000, Imm_Ext_E=5, RD_E=1, RS1_E=0, RD1_E=0.
- Writeback then sub:
  - Stimulus: write x1=7 and x2=3 via RegWriteW, then InstrD=0x402081B3.
  - Expect: RD1_E=7, RD2_E=3, ALUControlE=001, RD_E=3, ALUSrcE=0.
  - Also write RDW=0 with ResultW=0xFFFFFFFF → x0 still reads 0.
- sw then beq:
  - sw: 0x0020A423 → MemWriteE=1, RegWriteE=0, Imm_Ext_E=8.
  - beq: 0xFE000EE3 → BranchE=1, ALUControlE=001, Imm_Ext_E=0xFFFFFFFC.
- FlushE: FlushE=1 with a valid lw (0x0000A183) and a simultaneous write x5=9 → all *E outputs 0; x5 reads 9 next cycle.
- Same-cycle write/read: RegWriteW=1, RDW=1, ResultW=0x55 with InstrD reading rs1=x1 → RD1_E=0x55 with REGFILE_BYPASS_EN defined, the old value without it.
